// File: rtl/core_inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: geometry, packet bit
// positions, the idle packet and the FSM state encoding.
package core_inst_sequencer_pkg;

  localparam int ROW     = 8;   // PE rows; weight words per kernel position
  localparam int COL     = 8;   // PE columns; sets the flush wait
  localparam int ADDR_W  = 11;  // SRAM address width
  localparam int INST_BW = 38;  // instruction width
  localparam int KW      = 4;   // width of the kernel-position count

  // Instruction packet bit positions
  localparam int B_SFU_RELU   = 37;
  localparam int B_SFU_ACC    = 36;
  localparam int B_LD_MODE    = 35;
  localparam int B_OP_MODE    = 34;
  localparam int B_ACC        = 33;
  localparam int B_CEN_PMEM   = 32;
  localparam int B_WEN_PMEM   = 31;
  localparam int B_A_PMEM_LSB = 20;
  localparam int B_CEN_XMEM   = 19;
  localparam int B_WEN_XMEM   = 18;
  localparam int B_A_XMEM_LSB = 7;
  localparam int B_OFIFO_RD   = 6;
  localparam int B_IFIFO_WR   = 5;
  localparam int B_IFIFO_RD   = 4;
  localparam int B_L0_RD      = 3;
  localparam int B_L0_WR      = 2;
  localparam int B_EXECUTE    = 1;
  localparam int B_LOAD       = 0;

  // Both SRAMs deselected (active-low CEN/WEN high), every strobe low
  localparam logic [INST_BW-1:0] IDLE_INST =
      (INST_BW'(1) << B_CEN_PMEM) | (INST_BW'(1) << B_WEN_PMEM) |
      (INST_BW'(1) << B_CEN_XMEM) | (INST_BW'(1) << B_WEN_XMEM);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RD,
    S_W_LD,
    S_W_FL,
    S_X_RD,
    S_X_EX,
    S_DRAIN,
    S_SFU,
    S_DONE
  } state_e;

endpackage

// File: rtl/core_inst_sequencer_inst_field_pack.sv
// Combinational assembly of the core instruction packet from its field values.
module inst_field_pack
  import core_inst_sequencer_pkg::*;
(
  input  logic              sfu_relu,
  input  logic              sfu_acc,
  input  logic              ld_mode,
  input  logic              op_mode,
  input  logic              acc,
  input  logic              cen_pmem,
  input  logic              wen_pmem,
  input  logic [ADDR_W-1:0] a_pmem,
  input  logic              cen_xmem,
  input  logic              wen_xmem,
  input  logic [ADDR_W-1:0] a_xmem,
  input  logic              ofifo_rd,
  input  logic              ififo_wr,
  input  logic              ififo_rd,
  input  logic              l0_rd,
  input  logic              l0_wr,
  input  logic              execute,
  input  logic              load,
  output logic [INST_BW-1:0] inst
);

  // Place every field at its fixed bit position
  always_comb begin
    inst                            = '0;
    inst[B_SFU_RELU]                = sfu_relu;
    inst[B_SFU_ACC]                 = sfu_acc;
    inst[B_LD_MODE]                 = ld_mode;
    inst[B_OP_MODE]                 = op_mode;
    inst[B_ACC]                     = acc;
    inst[B_CEN_PMEM]                = cen_pmem;
    inst[B_WEN_PMEM]                = wen_pmem;
    inst[B_A_PMEM_LSB +: ADDR_W]    = a_pmem;
    inst[B_CEN_XMEM]                = cen_xmem;
    inst[B_WEN_XMEM]                = wen_xmem;
    inst[B_A_XMEM_LSB +: ADDR_W]    = a_xmem;
    inst[B_OFIFO_RD]                = ofifo_rd;
    inst[B_IFIFO_WR]                = ififo_wr;
    inst[B_IFIFO_RD]                = ififo_rd;
    inst[B_L0_RD]                   = l0_rd;
    inst[B_L0_WR]                   = l0_wr;
    inst[B_EXECUTE]                 = execute;
    inst[B_LOAD]                    = load;
  end

endmodule

// File: rtl/core_inst_sequencer.sv
// Per-tile instruction sequencer: for each kernel position load weights,
// stream activations, drain the output FIFO into psum SRAM (accumulating
// after the first position), then run one SFU pass over the tile.
// The packet for the current state is registered, so inst trails the
// state register by one cycle; all relative timings are kept in that frame.
module core_inst_sequencer
  import core_inst_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  w_base,
  input  logic [ADDR_W-1:0]  x_base,
  input  logic [ADDR_W-1:0]  p_base,
  input  logic [ADDR_W-1:0]  n_act,
  input  logic [KW-1:0]      nk,
  input  logic               relu_en,
  input  logic               ofifo_valid,
  output logic [INST_BW-1:0] inst,
  output logic               busy,
  output logic               done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   w_off_q, w_off_d;    // w_base + k*ROW
  logic [ADDR_W-1:0]   x_off_q, x_off_d;    // x_base + k*NA
  logic [ADDR_W-1:0]   p_base_q, p_base_d;
  logic [ADDR_W-1:0]   na_q, na_d;
  logic [KW-1:0]       nk_q, nk_d;
  logic                relu_q, relu_d;
  logic [ADDR_W-1:0]   i_q, i_d;            // word index within a phase
  logic [ADDR_W-1:0]   j_q, j_d;            // output row index
  logic [KW-1:0]       k_q, k_d;            // kernel position
  logic                rd_dly_q, rd_dly_d;  // xmem read issued last packet
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   wr_j_q, wr_j_d;
  logic                wr_acc_q, wr_acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [INST_BW-1:0]  inst_q, inst_pkt;

  logic [ADDR_W-1:0]   na_last;
  logic [KW-1:0]       k_last;

  logic                f_sfu_relu, f_sfu_acc, f_ld_mode, f_acc;
  logic                f_cen_pmem, f_wen_pmem, f_cen_xmem;
  logic [ADDR_W-1:0]   f_a_pmem, f_a_xmem;
  logic                f_ofifo_rd, f_l0_rd, f_l0_wr, f_execute, f_load;

  assign na_last = na_q - ADDR_W'(1);
  assign k_last  = nk_q - KW'(1);

  // Next-state, counter and packet-field computation for the current state
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    w_off_d    = w_off_q;
    x_off_d    = x_off_q;
    p_base_d   = p_base_q;
    na_d       = na_q;
    nk_d       = nk_q;
    relu_d     = relu_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    wr_j_d     = wr_j_q;
    wr_acc_d   = wr_acc_q;
    wr_pend_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    f_sfu_relu = 1'b0;
    f_sfu_acc  = 1'b0;
    f_ld_mode  = 1'b0;
    f_cen_xmem = 1'b1;
    f_a_xmem   = '0;
    f_ofifo_rd = 1'b0;
    f_l0_rd    = 1'b0;
    f_execute  = 1'b0;
    f_load     = 1'b0;
    // Read data lands one cycle after the xmem read: write it into L0 then
    f_l0_wr    = rd_dly_q;
    // A drained row is written to psum SRAM the cycle after it was popped
    f_cen_pmem = ~wr_pend_q;
    f_wen_pmem = ~wr_pend_q;
    f_acc      = wr_pend_q & wr_acc_q;
    f_a_pmem   = wr_pend_q ? p_base_q + wr_j_q : '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          w_off_d  = w_base;
          x_off_d  = x_base;
          p_base_d = p_base;
          na_d     = n_act;
          nk_d     = nk;
          relu_d   = relu_en;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          if (n_act == '0 || nk == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_W_RD;
          end
        end
      end
      S_W_RD: begin
        f_cen_xmem = 1'b0;
        f_a_xmem   = w_off_q + i_q;
        f_ld_mode  = 1'b1;
        if (i_q == ADDR_W'(ROW - 1)) begin
          i_d     = '0;
          state_d = S_W_LD;
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      S_W_LD: begin
        f_l0_rd   = 1'b1;
        f_load    = 1'b1;
        f_ld_mode = 1'b1;
        if (i_q == ADDR_W'(ROW - 1)) begin
          i_d     = '0;
          state_d = S_W_FL;
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      S_W_FL: begin
        if (i_q == ADDR_W'(ROW + COL - 1)) begin
          i_d     = '0;
          state_d = S_X_RD;
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      S_X_RD: begin
        f_cen_xmem = 1'b0;
        f_a_xmem   = x_off_q + i_q;
        if (i_q == na_last) begin
          i_d     = '0;
          state_d = S_X_EX;
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      S_X_EX: begin
        f_l0_rd   = 1'b1;
        f_execute = 1'b1;
        if (i_q == na_last) begin
          i_d     = '0;
          j_d     = '0;
          state_d = S_DRAIN;
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Address stays on the last written row while the FIFO is empty
        f_a_pmem = p_base_q + wr_j_q;
        if (j_q == na_q) begin
          // Last kernel fully popped: let its final write go out, then SFU
          j_d     = '0;
          state_d = S_SFU;
        end else if (ofifo_valid) begin
          f_ofifo_rd = 1'b1;
          wr_pend_d  = 1'b1;
          wr_j_d     = j_q;
          wr_acc_d   = (k_q != '0);
          if (j_q == na_last && k_q != k_last) begin
            // The pending write overlaps the first weight read; different SRAMs
            j_d     = '0;
            k_d     = k_q + KW'(1);
            w_off_d = w_off_q + ADDR_W'(ROW);
            x_off_d = x_off_q + na_q;
            state_d = S_W_RD;
          end else begin
            j_d = j_q + ADDR_W'(1);
          end
        end
      end
      S_SFU: begin
        f_cen_pmem = 1'b0;
        f_wen_pmem = 1'b1;
        f_a_pmem   = p_base_q + j_q;
        f_sfu_acc  = 1'b1;
        f_sfu_relu = relu_q;
        if (j_q == na_last) begin
          j_d     = '0;
          state_d = S_DONE;
        end else begin
          j_d = j_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_dly_d = ~f_cen_xmem;
  end

  inst_field_pack u_pack (
    .sfu_relu (f_sfu_relu),
    .sfu_acc  (f_sfu_acc),
    .ld_mode  (f_ld_mode),
    .op_mode  (1'b0),
    .acc      (f_acc),
    .cen_pmem (f_cen_pmem),
    .wen_pmem (f_wen_pmem),
    .a_pmem   (f_a_pmem),
    .cen_xmem (f_cen_xmem),
    .wen_xmem (1'b1),
    .a_xmem   (f_a_xmem),
    .ofifo_rd (f_ofifo_rd),
    .ififo_wr (1'b0),
    .ififo_rd (1'b0),
    .l0_rd    (f_l0_rd),
    .l0_wr    (f_l0_wr),
    .execute  (f_execute),
    .load     (f_load),
    .inst     (inst_pkt)
  );

  // State, counters and registered outputs; synchronous reset aborts a run
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      w_off_q   <= '0;
      x_off_q   <= '0;
      p_base_q  <= '0;
      na_q      <= '0;
      nk_q      <= '0;
      relu_q    <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      rd_dly_q  <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_j_q    <= '0;
      wr_acc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      inst_q    <= IDLE_INST;
    end else begin
      state_q   <= state_d;
      w_off_q   <= w_off_d;
      x_off_q   <= x_off_d;
      p_base_q  <= p_base_d;
      na_q      <= na_d;
      nk_q      <= nk_d;
      relu_q    <= relu_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      rd_dly_q  <= rd_dly_d;
      wr_pend_q <= wr_pend_d;
      wr_j_q    <= wr_j_d;
      wr_acc_q  <= wr_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      inst_q    <= inst_pkt;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench for core_inst_sequencer: each tile's expected xmem
// reads, psum writes and SFU reads are listed up front from the tile
// configuration and matched in order against the packets the DUT emits.
module tb_core_inst_sequencer;

  localparam logic [37:0] IDLE_INST = 38'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] w_base, x_base, p_base, n_act;
  logic [3:0]  nk;
  logic        relu_en, ofifo_valid;
  logic [37:0] inst;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  core_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_base      (w_base),
    .x_base      (x_base),
    .p_base      (p_base),
    .n_act       (n_act),
    .nk          (nk),
    .relu_en     (relu_en),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Config after the accepted start must be ignored; keep it moving
  task automatic scramble();
    w_base  = 11'($urandom);
    x_base  = 11'($urandom);
    p_base  = 11'($urandom);
    n_act   = 11'($urandom);
    nk      = 4'($urandom);
    relu_en = 1'($urandom);
  endtask

  // vmode: 0 ofifo_valid always high, 1 random, 2 five-cycle stall after first write
  task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                          input logic [10:0] na, input logic [3:0] nkk, input logic relu,
                          input int vmode, input bit dbl_start, input int abort_exec);
    logic [11:0] xq[$];  // {is_weight, addr}
    logic [11:0] pq[$];  // {acc, addr}
    logic [10:0] sq[$];
    logic [11:0] e;
    logic [10:0] ea;
    logic [10:0] prev_a;
    logic [37:0] f;
    logic        prev_xrd, prev_ord, xrd, pw, sr, degenerate, finished;
    int          done_cnt, tail, load_cnt, exec_cnt, low_run, stall_lows;
    bit          stall_started;

    degenerate = (na == 0) || (nkk == 0);
    if (!degenerate) begin
      for (int k = 0; k < int'(nkk); k++) begin
        for (int i = 0; i < 8; i++)         xq.push_back({1'b1, 11'(int'(wb) + k * 8 + i)});
        for (int i = 0; i < int'(na); i++)  xq.push_back({1'b0, 11'(int'(xb) + k * int'(na) + i)});
        for (int j = 0; j < int'(na); j++)  pq.push_back({k != 0, 11'(int'(pb) + j)});
      end
      for (int j = 0; j < int'(na); j++) sq.push_back(11'(int'(pb) + j));
    end

    prev_xrd = 1'b0; prev_ord = 1'b0; prev_a = '0; finished = 1'b0;
    done_cnt = 0; tail = 0; load_cnt = 0; exec_cnt = 0; low_run = 0; stall_lows = 0;
    stall_started = 1'b0;

    @(negedge clk);
    w_base = wb; x_base = xb; p_base = pb; n_act = na; nk = nkk; relu_en = relu;
    start = 1'b1; ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      f = inst;
      if (cyc == 0) begin
        check("busy_after_start", busy, !degenerate);
        check("done_after_start", done, degenerate);
      end
      xrd = !f[19];
      if (xrd) begin
        check("xmem_wen_high", f[18], 1);
        if (xq.size() == 0) check("xmem_extra_read", 1, 0);
        else begin
          e = xq.pop_front();
          check("xmem_addr", f[17:7], e[10:0]);
          check("ld_mode_on_read", f[35], e[11]);
        end
      end
      check("l0_wr_lag", f[2], prev_xrd);
      if (f[6]) check("ofifo_rd_needs_valid", ofifo_valid, 1);
      pw = !f[32] && !f[31];
      sr = !f[32] && f[31];
      if (pw) begin
        check("pmem_write_after_ofifo_rd", prev_ord, 1);
        if (pq.size() == 0) check("pmem_extra_write", 1, 0);
        else begin
          e = pq.pop_front();
          check("pmem_wr_addr", f[30:20], e[10:0]);
          check("pmem_wr_acc", f[33], e[11]);
        end
        stall_started = 1'b1;
      end
      if (sr) begin
        check("sfu_after_drain", pq.size(), 0);
        if (sq.size() == 0) check("sfu_extra_read", 1, 0);
        else begin
          ea = sq.pop_front();
          check("sfu_addr", f[30:20], ea);
          check("sfu_acc", f[36], 1);
          check("sfu_relu", f[37], relu);
        end
      end
      if (vmode == 2 && low_run >= 2) begin
        check("a_pmem_frozen", f[30:20], prev_a);
        check("no_pmem_in_stall", f[32], 1);
      end
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", busy, 0);
      end
      if (done_cnt > 0) begin
        tail++;
        if (tail > 3) finished = 1'b1;
      end
      load_cnt += int'(f[0]);
      exec_cnt += int'(f[1]);
      prev_xrd = xrd;
      prev_ord = f[6];
      prev_a   = f[30:20];

      if (abort_exec > 0 && exec_cnt >= abort_exec) begin
        reset = 1'b1;
        @(negedge clk);
        check("abort_inst_idle", inst, IDLE_INST);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        return;
      end

      if (dbl_start) start = (cyc == 10);
      case (vmode)
        0: ofifo_valid = 1'b1;
        1: ofifo_valid = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_started && stall_lows < 5) begin
            ofifo_valid = 1'b0;
            stall_lows++;
          end else begin
            ofifo_valid = 1'b1;
          end
        end
      endcase
      low_run = ofifo_valid ? 0 : low_run + 1;
      @(negedge clk);
    end
    start = 1'b0;

    if (!finished) check("timeout_waiting_done", 0, 1);
    check("done_pulse_count", done_cnt, 1);
    check("xmem_reads_left", xq.size(), 0);
    check("pmem_writes_left", pq.size(), 0);
    check("sfu_reads_left", sq.size(), 0);
    check("load_count", load_cnt, degenerate ? 0 : 8 * int'(nkk));
    check("execute_count", exec_cnt, degenerate ? 0 : int'(na) * int'(nkk));
    if (vmode == 2) check("stall_applied", stall_lows, 5);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; n_act = '0; nk = '0; relu_en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_inst", inst, IDLE_INST);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;

    // Single kernel position, weights at 0, activations at 16
    run_tile(11'd0, 11'd16, 11'd0, 11'd4, 4'd1, 1'b0, 0, 1'b0, 0);
    // Three kernel positions: strided reads and accumulate after k=0
    run_tile(11'd0, 11'd100, 11'd40, 11'd2, 4'd3, 1'b1, 0, 1'b0, 0);
    // Output FIFO runs dry mid-drain
    run_tile(11'd32, 11'd64, 11'd8, 11'd4, 4'd1, 1'b1, 2, 1'b0, 0);
    // Degenerate tiles finish at once without memory traffic
    run_tile(11'd5, 11'd6, 11'd7, 11'd0, 4'd2, 1'b0, 0, 1'b0, 0);
    run_tile(11'd5, 11'd6, 11'd7, 11'd5, 4'd0, 1'b1, 0, 1'b0, 0);
    // psum address wrap, with a stray start while busy
    run_tile(11'd2040, 11'd2045, 11'd2046, 11'd4, 4'd2, 1'b1, 1, 1'b1, 0);
    // Reset during the second kernel's execute phase, then a clean run
    run_tile(11'd0, 11'd16, 11'd0, 11'd4, 4'd2, 1'b0, 0, 1'b0, 5);
    run_tile(11'd10, 11'd200, 11'd300, 11'd3, 4'd2, 1'b1, 1, 1'b0, 0);

    // Random tiles against the listed-out expectations
    for (int t = 0; t < 6; t++) begin
      run_tile(11'($urandom), 11'($urandom), 11'($urandom),
               11'($urandom_range(1, 6)), 4'($urandom_range(1, 3)), 1'($urandom),
               $urandom_range(0, 1), 1'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
